// File: rtl/fetch_unit.sv
// Instruction fetch and sequencing stage: reads 16-bit words over a req/valid handshake,
// hands each one to the control unit with a run pulse, then advances or branches the PC on done.
module fetch_unit #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]       HALT_WORD = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_valid,
  output logic [15:0]       instruction,
  output logic              run,
  input  logic              done,
  input  logic [1:0]        cmp_flags,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       retired
);

  // state | meaning: IDLE wait for start | REQ read strobe | WAIT await read data
  //   ISSUE run pulse | EXEC await done | HALTED halt word fetched, only reset leaves
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic [15:0]       instr_next;
  logic [15:0]       retired_next;
  logic              taken;

  assign pc_inc = pc + ADDR_W'(1);
  assign target = instruction[ADDR_W+3:4];

  always_comb begin
    taken = 1'b0;
    if (instruction[1:0] == 2'b10) begin
      case (instruction[3:2])
        2'b00:   taken = (cmp_flags == 2'b00);
        2'b01:   taken = (cmp_flags == 2'b01);
        2'b10:   taken = (cmp_flags == 2'b10);
        default: taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    instr_next   = instruction;
    retired_next = retired;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_REQ;
      end
      S_REQ: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (mem_valid) begin
          instr_next = mem_rdata;
          state_next = (mem_rdata == HALT_WORD) ? S_HALTED : S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_next = S_EXEC;
      end
      S_EXEC: begin
        if (done) begin
          retired_next = retired + 16'd1;
          pc_next      = taken ? target : pc_inc;
          state_next   = S_REQ;
        end
      end
      S_HALTED: begin
        state_next = S_HALTED;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instruction <= '0;
      retired     <= '0;
      mem_req     <= 1'b0;
      run         <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instruction <= instr_next;
      retired     <= retired_next;
      mem_req     <= (state_next == S_REQ);
      run         <= (state_next == S_ISSUE);
    end
  end

  assign mem_addr = pc;
  assign busy     = (state != S_IDLE) && (state != S_HALTED);
  assign halted   = (state == S_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a behavioural model of the fetch/issue/retire sequence.
module tb_fetch_unit;
  localparam int          AW   = 8;
  localparam logic [15:0] HALT = 16'hFFFF;
  localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_ISSUE = 3, P_EXEC = 4, P_HALT = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          mem_valid = 1'b0;
  logic [15:0]   mem_rdata = 16'h0;
  logic          done = 1'b0;
  logic [1:0]    cmp_flags = 2'b11;
  logic          mem_req, run, busy, halted;
  logic [AW-1:0] mem_addr, pc;
  logic [15:0]   instruction, retired;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(AW), .RESET_PC(8'h00), .HALT_WORD(HALT)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .instruction(instruction), .run(run),
    .done(done), .cmp_flags(cmp_flags), .pc(pc), .busy(busy), .halted(halted),
    .retired(retired)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: where the sequence is, what has been fetched and retired.
  int          m_phase = P_IDLE;
  logic [7:0]  m_pc = 8'h00;
  logic [15:0] m_instr = 16'h0;
  logic [15:0] m_ret = 16'h0;
  bit          m_ok = 1'b0;

  function automatic logic [7:0] ref_next(input logic [7:0] p, input logic [15:0] w,
                                          input logic [1:0] f);
    int cond;
    int tgt;
    cond = int'(w[3:2]);
    tgt  = int'(w >> 4) % 256;
    if (w[1:0] == 2'b10 && cond != 3 && cond == int'(f)) return 8'(tgt);
    return 8'((int'(p) + 1) % 256);
  endfunction

  always @(posedge clk) begin
    m_ok <= 1'b1;
    if (!reset) begin
      m_phase <= P_IDLE;
      m_pc    <= 8'h00;
      m_instr <= 16'h0;
      m_ret   <= 16'h0;
    end else begin
      case (m_phase)
        P_IDLE:  if (start) m_phase <= P_REQ;
        P_REQ:   m_phase <= P_WAIT;
        P_WAIT:  if (mem_valid) begin
                   m_instr <= mem_rdata;
                   m_phase <= (mem_rdata == HALT) ? P_HALT : P_ISSUE;
                 end
        P_ISSUE: m_phase <= P_EXEC;
        P_EXEC:  if (done) begin
                   m_ret   <= m_ret + 16'd1;
                   m_pc    <= ref_next(m_pc, m_instr, cmp_flags);
                   m_phase <= P_REQ;
                 end
        default: ;
      endcase
    end
  end

  logic [7:0]  req_log[$];
  logic [15:0] issued[$];
  int          run_cnt = 0;

  always @(negedge clk) begin
    if (m_ok) begin
      chk("mem_req", mem_req, m_phase == P_REQ);
      chk("run", run, m_phase == P_ISSUE);
      chk("pc", pc, m_pc);
      chk("mem_addr", mem_addr, m_pc);
      chk("instruction", instruction, m_instr);
      chk("retired", retired, m_ret);
      chk("busy", busy, m_phase != P_IDLE && m_phase != P_HALT);
      chk("halted", halted, m_phase == P_HALT);
      if (mem_req) req_log.push_back(mem_addr);
      if (run) begin
        run_cnt++;
        issued.push_back(instruction);
      end
    end
  end

  // Memory and control-unit responders.
  logic [15:0] mem[0:255];
  int   lat_min = 1, lat_max = 1, dly_min = 2, dly_max = 2;
  bit   spur = 1'b0, spur_at_run = 1'b0, force_spur = 1'b0, rand_flags = 1'b0;
  logic [1:0] flags_fixed = 2'b11;
  bit   rd_pend = 1'b0, dn_pend = 1'b0;
  int   rd_cnt = 0, dn_cnt = 0;
  logic [7:0] rd_addr = 8'h0;

  always @(posedge clk) begin
    #1;
    mem_valid = 1'b0;
    mem_rdata = 16'($urandom);
    done      = 1'b0;
    cmp_flags = rand_flags ? 2'($urandom) : flags_fixed;
    if (rd_pend) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        mem_valid = 1'b1;
        mem_rdata = mem[rd_addr];
        rd_pend   = 1'b0;
      end
    end else if (spur && $urandom_range(0, 9) == 0) begin
      mem_valid = 1'b1;
    end
    if (mem_req) begin
      rd_pend = 1'b1;
      rd_cnt  = $urandom_range(lat_max, lat_min);
      rd_addr = mem_addr;
    end
    if (dn_pend) begin
      dn_cnt--;
      if (dn_cnt == 0) begin
        done    = 1'b1;
        dn_pend = 1'b0;
      end
    end else if (spur && $urandom_range(0, 9) == 0) begin
      done = 1'b1;
    end
    if (run) begin
      dn_pend = 1'b1;
      dn_cnt  = $urandom_range(dly_max, dly_min);
      if (spur_at_run) begin
        done      = 1'b1;
        mem_valid = 1'b1;
        mem_rdata = 16'hBEEF;
      end
    end
    if (force_spur) begin
      done      = 1'b1;
      mem_valid = 1'b1;
      mem_rdata = 16'hBEEF;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_logs();
    req_log.delete();
    issued.delete();
    run_cnt = 0;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = HALT;
  endtask

  task automatic cfg(input int lmin, input int lmax, input int dmin, input int dmax,
                     input logic [1:0] fl);
    lat_min = lmin; lat_max = lmax; dly_min = dmin; dly_max = dmax; flags_fixed = fl;
  endtask

  task automatic wait_halted(input string name, input int max);
    int i = 0;
    while (!halted && i < max) begin
      tick();
      i++;
    end
    chk({name, "_halted"}, halted, 1);
  endtask

  task automatic wait_reqs(input string name, input int n, input int max);
    int i = 0;
    while (req_log.size() < n && i < max) begin
      tick();
      i++;
    end
    chk({name, "_nreq"}, req_log.size(), n);
  endtask

  logic [7:0] ex[$];

  task automatic chk_addrs(input string name);
    chk({name, "_addr_cnt"}, req_log.size(), ex.size());
    for (int i = 0; i < ex.size() && i < req_log.size(); i++)
      chk($sformatf("%s_addr%0d", name, i), req_log[i], ex[i]);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_pc", pc, 0);
    chk("rst_retired", retired, 0);
    chk("rst_busy", busy, 0);
    chk("rst_instr", instruction, 0);
    reset = 1'b1;

    // Straight-line program ending in the halt word.
    fill_halt();
    mem[0] = 16'h0020; mem[1] = 16'h0041; mem[2] = HALT;
    cfg(1, 1, 2, 2, 2'b11);
    clear_logs();
    pulse_start();
    chk("t1_req_latency", mem_req, 1);
    tick();
    tick();
    chk("t1_run_latency", run, 1);
    wait_halted("t1", 100);
    ex = '{8'h00, 8'h01, 8'h02};
    chk_addrs("t1");
    chk("t1_runs", run_cnt, 2);
    chk("t1_pc", pc, 8'h02);
    chk("t1_retired", retired, 2);

    // Branch taken (BEQ, flags equal) then not taken (BEQ, flags greater).
    fill_halt();
    mem[0] = 16'h0052; mem[5] = 16'h0A02;
    cfg(1, 2, 1, 3, 2'b00);
    do_reset();
    clear_logs();
    pulse_start();
    wait_halted("t2a", 100);
    ex = '{8'h00, 8'h05, 8'hA0};
    chk_addrs("t2a");
    chk("t2a_pc", pc, 8'hA0);
    chk("t2a_retired", retired, 2);

    mem[0] = 16'h0056;
    cfg(1, 2, 1, 3, 2'b01);
    do_reset();
    clear_logs();
    pulse_start();
    wait_halted("t2b", 100);
    ex = '{8'h00, 8'h05, 8'h06};
    chk_addrs("t2b");
    chk("t2b_pc", pc, 8'h06);

    // PC wrap from 255 to 0.
    fill_halt();
    mem[0] = 16'h0FF2; mem[255] = 16'h1234;
    cfg(1, 1, 1, 2, 2'b00);
    do_reset();
    clear_logs();
    pulse_start();
    wait_reqs("t3", 3, 100);
    ex = '{8'h00, 8'hFF, 8'h00};
    chk_addrs("t3");
    chk("t3_pc", pc, 8'h00);
    chk("t3_retired", retired, 2);

    // Slow memory with stray valid/done while idle and during the run pulse.
    fill_halt();
    mem[0] = 16'h0004;
    cfg(5, 5, 3, 3, 2'b11);
    do_reset();
    clear_logs();
    force_spur = 1'b1;
    tick();
    tick();
    force_spur  = 1'b0;
    spur_at_run = 1'b1;
    tick();
    tick();
    chk("t4_idle_instr", instruction, 0);
    pulse_start();
    wait_halted("t4", 200);
    spur_at_run = 1'b0;
    chk("t4_runs", run_cnt, 1);
    chk("t4_issued_cnt", issued.size(), 1);
    if (issued.size() > 0) chk("t4_issued_word", issued[0], 16'h0004);
    chk("t4_retired", retired, 1);
    chk("t4_pc", pc, 8'h01);

    // Reset while a read is outstanding.
    cfg(6, 6, 2, 2, 2'b11);
    do_reset();
    clear_logs();
    pulse_start();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t5_busy", busy, 0);
    chk("t5_req", mem_req, 0);
    chk("t5_run", run, 0);
    chk("t5_pc", pc, 0);
    chk("t5_instr", instruction, 0);
    chk("t5_halted", halted, 0);
    repeat (8) tick();
    chk("t5_late_busy", busy, 0);
    chk("t5_late_instr", instruction, 0);
    pulse_start();
    chk("t5_refetch_req", mem_req, 1);
    chk("t5_refetch_addr", mem_addr, 8'h00);
    wait_halted("t5", 100);
    chk("t5_retired", retired, 1);

    // start held high through EXEC and HALTED.
    cfg(1, 1, 4, 4, 2'b11);
    do_reset();
    clear_logs();
    tick();
    start = 1'b1;
    wait_halted("t6", 100);
    chk("t6_nreq", req_log.size(), 2);
    repeat (5) tick();
    chk("t6_still_halted", halted, 1);
    chk("t6_no_restart", req_log.size(), 2);
    start = 1'b0;
    do_reset();
    pulse_start();
    chk("t6_restart_req", mem_req, 1);
    chk("t6_restart_addr", mem_addr, 8'h00);
    wait_halted("t6b", 100);

    // Randomized traffic against the model.
    for (int i = 0; i < 256; i++) begin
      int r;
      r = $urandom_range(0, 31);
      mem[i] = 16'($urandom);
      if (r < 12) mem[i][1:0] = 2'b10;
      if (r == 0) mem[i] = HALT;
    end
    cfg(1, 4, 1, 4, 2'b00);
    rand_flags = 1'b1;
    spur       = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      reset = halted ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 3) == 0);
    end
    spur = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and sequencing stage directly upstream of the control unit.
- Holds the program counter and reads 16-bit instruction words from instruction memory over a req/valid handshake.
- Presents each word, stable, to the control unit and pulses run; waits for the control unit's done; then computes the next PC, resolving format-10 branches.

Parameters:
- ADDR_W, 8, PC and instruction-memory address width (1..12).
- RESET_PC, 0, PC value after reset.
- HALT_WORD, 16'hFFFF, instruction encoding that stops fetching.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  begin fetching from current PC; honoured only in IDLE.
- mem_req  output  1  one-cycle read request to instruction memory.
- mem_addr  output  ADDR_W  read address; always equals pc.
- mem_rdata  input  16  read data, valid with mem_valid.
- mem_valid  input  1  read data strobe; sampled only in WAIT.
- instruction  output  16  registered instruction word to the control unit.
- run  output  1  one-cycle pulse telling the control unit to execute instruction.
- done  input  1  control unit has finished the current instruction; sampled only in EXEC.
- cmp_flags  input  2  ALU compare result: 00 equal, 01 greater, 10 less, 11 none.
- pc  output  ADDR_W  current program counter.
- busy  output  1  high in every state except IDLE and HALTED.
- halted  output  1  high in HALTED.
- retired  output  16  count of completed instructions.

Behaviour:
- Reset (reset==0 at a clk edge, any state) forces the following, aborting any outstanding read:
  - state IDLE, pc=RESET_PC, instruction=0, run=0, mem_req=0, retired=0, halted=0, busy=0.
  - A mem_valid arriving later is ignored.
- The state register and all outputs are registered, except that mem_addr, busy and halted decode from state and pc.
- States are IDLE, REQ, WAIT, ISSUE, EXEC, HALTED.
- IDLE: outputs idle. start=1 -> REQ.
- REQ: mem_req=1 for exactly this cycle, with mem_addr=pc -> WAIT.
- WAIT: mem_req=0.
  - On mem_valid=1, instruction<=mem_rdata.
  - If mem_rdata==HALT_WORD -> HALTED, else -> ISSUE.
  - With no mem_valid, stay in WAIT indefinitely. There is no timeout. Minimum read latency is 1 cycle.
- ISSUE: run=1 for exactly one cycle -> EXEC.
- EXEC: run=0; instruction is held stable.
  - When done=1:
    - retired<=retired+1, wrapping at 16'hFFFF->0.
    - pc<=next_pc.
    - -> REQ.
- HALTED: all strobes 0 and pc frozen. Only reset leaves HALTED; start is ignored.
- next_pc rules:
  - Default: pc+1 modulo 2^ADDR_W (255->0 for ADDR_W=8).
  - Branch when instruction[1:0]==2'b10. Target = instruction[ADDR_W+3:4]. Condition field = instruction[3:2], evaluated against cmp_flags in the same cycle done=1:
    - 00 BEQ: taken if cmp_flags==00.
    - 01 BGT: taken if cmp_flags==01.
    - 10 BLT: taken if cmp_flags==10.
    - 11: never taken.
  - Taken -> target; not taken -> pc+1.
- Timing: start at edge N gives mem_req at N+1. With 1-cycle memory, run is high at N+3, and the next mem_req follows one cycle after done.
- Ignored inputs:
  - start outside IDLE.
  - done outside EXEC, including a done that coincides with run.
  - mem_valid outside WAIT.
- The halt word does not increment retired and is never issued with run.

Test Plan:
1. Memory 0:16'h0020, 1:16'h0041, 2:16'hFFFF; 1-cycle latency; done 2 cycles after each run.
   -> mem_addr sequence 0,1,2.
   -> run pulses twice, each exactly 1 cycle.
   -> halted=1 with pc=2 and retired=2.
2. Branch taken: word at pc=5 is 16'h0A02 (format 10, cond 00, target 8'hA0), cmp_flags=00 at done.
   -> next mem_addr=8'hA0.
   The same word with cmp_flags=01 -> next mem_addr=6.
3. Wrap: pc=255, non-branch word, done -> pc=0, mem_addr=0.
4. Variable latency: mem_valid delayed 5 cycles, with spurious mem_valid and done pulses while in ISSUE/IDLE.
   -> instruction captured only on the WAIT-state mem_valid.
   -> no extra run pulse.
   -> retired increments once.
5. Reset mid-operation: drive reset=0 for one cycle while in WAIT.
   -> all outputs at reset values next cycle.
   -> a late mem_valid is ignored.
   -> a later start refetches from RESET_PC.
6. Start ignored: start held high during EXEC.
   -> no extra mem_req.
   -> after HALTED, start does not restart; reset then start does.
